sample_fifo: RTL and testbench

SAMPLE_FIFO -- requirements
Module: sample_fifo

---
 rtl/sample_fifo_pkg.sv | 27 ++
 rtl/sample_fifo_ram.sv | 53 +++++
 rtl/sample_fifo.sv | 161 ++++++++++++++++
 tb/tb_sample_fifo.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sample_fifo_pkg.sv
//------------------------------------------------------------------------------
// sample_fifo_pkg
//   Shared audio definitions used by the sample FIFO, DSP and DAC blocks:
//   default sample width, channel count and the frame-width helper.
//   No ports (package).
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sample_fifo_pkg;

  // Default audio format: 16-bit stereo.
  localparam int AUDIO_SAMPLE_WIDTH = 16;
  localparam int AUDIO_CHANNELS     = 2;

  // A frame packs one sample per channel, channel 0 in the LSBs.
  function automatic int frame_width(input int sample_width, input int channels);
    return sample_width * channels;
  endfunction

  localparam int AUDIO_FRAME_WIDTH = frame_width(AUDIO_SAMPLE_WIDTH, AUDIO_CHANNELS);

  typedef logic [AUDIO_FRAME_WIDTH-1:0] audio_frame_t;

endpackage : sample_fifo_pkg

`default_nettype wire

// File: rtl/sample_fifo_ram.sv
//------------------------------------------------------------------------------
// sample_fifo_ram
//   Frame storage for sample_fifo: DEPTH x WIDTH array with one synchronous
//   write port and one synchronous (registered) read port. No reset on the
//   array or on the read register.
//   Ports:
//     clock      - rising-edge clock
//     wr_en_i    - write strobe
//     wr_addr_i  - write address
//     wr_data_i  - write data
//     rd_en_i    - read strobe; rd_data_o updates only when set
//     rd_addr_i  - read address
//     rd_data_o  - registered read data, holds between reads
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sample_fifo_ram
  import sample_fifo_pkg::*;
#(
  parameter int WIDTH = AUDIO_FRAME_WIDTH,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Read-before-write: when both ports hit the same address in one cycle
  // (full FIFO with simultaneous enqueue and dequeue) the read returns the
  // old frame, which is the one being dequeued.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule : sample_fifo_ram

`default_nettype wire

// File: rtl/sample_fifo.sv
//------------------------------------------------------------------------------
// sample_fifo
//   First-in-first-out buffer of multi-channel audio frames with registered
//   read data, occupancy level, status flags and sticky error flags.
//   Ports:
//     clock        - sole clock, rising edge
//     reset        - asynchronous, active-high
//     enqueue      - write request; input_frame is stored when accepted
//     input_frame  - frame to write, channel 0 in LSBs
//     dequeue      - read request
//     output_frame - registered read data, holds when no read is accepted
//     output_valid - one-cycle pulse when output_frame was newly loaded
//     level        - number of frames held, 0..DEPTH
//     full/empty/almost_full - status decoded from level
//     overflow     - sticky: enqueue rejected while full
//     underflow    - sticky: dequeue rejected while empty
//     clear_flags  - clears overflow/underflow (a new error the same cycle wins)
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sample_fifo
  import sample_fifo_pkg::*;
#(
  parameter int SAMPLE_WIDTH      = AUDIO_SAMPLE_WIDTH,
  parameter int CHANNELS          = AUDIO_CHANNELS,
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enqueue,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] input_frame,
  input  logic                             dequeue,
  output logic [CHANNELS*SAMPLE_WIDTH-1:0] output_frame,
  output logic                             output_valid,
  output logic [$clog2(DEPTH):0]           level,
  output logic                             full,
  output logic                             empty,
  output logic                             almost_full,
  output logic                             overflow,
  output logic                             underflow,
  input  logic                             clear_flags
);

  localparam int FW = frame_width(SAMPLE_WIDTH, CHANNELS);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LEVEL_AF   = LW'(ALMOST_FULL_LEVEL);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          valid_q, valid_d;
  logic          loaded_q, loaded_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          enq_acc;
  logic          deq_acc;
  logic [FW-1:0] ram_rd_data;

  // ---------------------------------------------------------------------------
  // Status decode (combinational from registered level)
  // ---------------------------------------------------------------------------
  assign full        = (level_q == LEVEL_FULL);
  assign empty       = (level_q == '0);
  assign almost_full = (level_q >= LEVEL_AF);

  // Dequeue has priority in deciding acceptance: a full FIFO can still take
  // a new frame if a slot is freed in the same cycle. An empty FIFO never
  // bypasses a write straight to the read side.
  assign deq_acc = dequeue && !empty;
  assign enq_acc = enqueue && (!full || deq_acc);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    valid_d     = deq_acc;
    loaded_d    = loaded_q || deq_acc;

    // DEPTH is a power of two, so the pointers wrap DEPTH-1 -> 0 naturally.
    if (enq_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (deq_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({enq_acc, deq_acc})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Sticky flags: clear_flags drops the old value, but an error raised in
    // the same cycle keeps the flag set.
    overflow_d  = (overflow_q  && !clear_flags) || (enqueue && !enq_acc);
    underflow_d = (underflow_q && !clear_flags) || (dequeue && !deq_acc);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      valid_q     <= 1'b0;
      loaded_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      valid_q     <= valid_d;
      loaded_q    <= loaded_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  sample_fifo_ram #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clock     (clock),
    .wr_en_i   (enq_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (input_frame),
    .rd_en_i   (deq_acc),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rd_data)
  );

  // The RAM read register carries no reset, so output_frame is gated by
  // loaded_q: it reads as zero from reset until the first accepted dequeue,
  // and reset forces it back to zero immediately.
  assign output_frame = loaded_q ? ram_rd_data : '0;
  assign output_valid = valid_q;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule : sample_fifo

`default_nettype wire

// File: tb/tb_sample_fifo.sv
//------------------------------------------------------------------------------
// tb_sample_fifo
//   Directed self-checking bench for sample_fifo with default parameters
//   (16-bit stereo, DEPTH 16, almost_full at 12).
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sample_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enqueue = 1'b0;
  logic [31:0] input_frame = '0;
  logic        dequeue = 1'b0;
  logic [31:0] output_frame;
  logic        output_valid;
  logic [4:0]  level;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        overflow;
  logic        underflow;
  logic        clear_flags = 1'b0;

  int errors = 0;
  int checks = 0;

  sample_fifo dut (
    .clock        (clock),
    .reset        (reset),
    .enqueue      (enqueue),
    .input_frame  (input_frame),
    .dequeue      (dequeue),
    .output_frame (output_frame),
    .output_valid (output_valid),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow),
    .clear_flags  (clear_flags)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Apply inputs, advance past one rising edge, land 1 time unit after it.
  task automatic cyc(input logic enq, input logic [31:0] din, input logic deq, input logic clr);
    enqueue     = enq;
    input_frame = din;
    dequeue     = deq;
    clear_flags = clr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #2;
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_frame", output_frame, 32'h0);
    check("rst_valid", 32'(output_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // ---------------- 4 enqueues, 4 dequeues ----------------
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'h0001_0002 + 32'(i) * 32'h0001_0001, 1'b0, 1'b0);
    end
    check("basic_level4", 32'(level), 32'd4);
    check("basic_valid_nodeq", 32'(output_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      check("basic_frame", output_frame, 32'h0001_0002 + 32'(i) * 32'h0001_0001);
      check("basic_valid", 32'(output_valid), 32'd1);
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check("basic_valid_end", 32'(output_valid), 32'd0);
    check("basic_hold", output_frame, 32'h0004_0005);
    check("basic_level0", 32'(level), 32'd0);
    check("basic_empty", 32'(empty), 32'd1);

    // ---------------- fill to full, overflow ----------------
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 32'h0000_1000 + 32'(i), 1'b0, 1'b0);
      check("fill_level", 32'(level), 32'(i + 1));
      check("fill_af", 32'(almost_full), ((i + 1) >= 12) ? 32'd1 : 32'd0);
      check("fill_full", 32'(full), (i == 15) ? 32'd1 : 32'd0);
    end
    check("fill_ovf_clean", 32'(overflow), 32'd0);
    cyc(1'b1, 32'hDEAD_DEAD, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_level", 32'(level), 32'd16);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    check("ovf_clear", 32'(overflow), 32'd0);
    check("ovf_unf_clean", 32'(underflow), 32'd0);

    // ---------------- full, simultaneous enqueue+dequeue ----------------
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 32'h0000_2000 + 32'(i), 1'b1, 1'b0);
      check("pass_level", 32'(level), 32'd16);
      check("pass_valid", 32'(output_valid), 32'd1);
      check("pass_frame", output_frame,
            (i < 16) ? (32'h0000_1000 + 32'(i)) : (32'h0000_2000 + 32'(i - 16)));
    end
    check("pass_ovf", 32'(overflow), 32'd0);
    // Drain: remaining frames are 0x2004..0x2013 in order.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      check("drain_frame", output_frame, 32'h0000_2004 + 32'(i));
    end
    check("drain_empty", 32'(empty), 32'd1);

    // ---------------- empty, simultaneous enqueue+dequeue ----------------
    cyc(1'b1, 32'hAAAA_5555, 1'b1, 1'b0);
    check("emp_level", 32'(level), 32'd1);
    check("emp_valid", 32'(output_valid), 32'd0);
    check("emp_unf", 32'(underflow), 32'd1);
    check("emp_hold", output_frame, 32'h0000_2013);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("emp_read", output_frame, 32'hAAAA_5555);
    check("emp_read_valid", 32'(output_valid), 32'd1);
    check("emp_unf_sticky", 32'(underflow), 32'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    check("unf_clear", 32'(underflow), 32'd0);

    // ---------------- clear_flags with new underflow ----------------
    cyc(1'b0, 32'h0, 1'b1, 1'b1);
    check("clr_unf_wins", 32'(underflow), 32'd1);
    check("clr_unf_valid", 32'(output_valid), 32'd0);
    check("clr_unf_hold", output_frame, 32'hAAAA_5555);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    check("clr_unf_after", 32'(underflow), 32'd0);

    // ---------------- asynchronous reset mid-operation ----------------
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'h0000_3000 + 32'(i), 1'b0, 1'b0);
    end
    enqueue = 1'b0;
    check("ar_level5", 32'(level), 32'd5);
    #2 reset = 1'b1;
    #1;
    check("ar_level", 32'(level), 32'd0);
    check("ar_empty", 32'(empty), 32'd1);
    check("ar_frame", output_frame, 32'h0);
    #1 reset = 1'b0;
    cyc(1'b1, 32'hBEEF_CAFE, 1'b0, 1'b0);
    check("ar_enq_level", 32'(level), 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("ar_frame_out", output_frame, 32'hBEEF_CAFE);
    check("ar_valid_out", 32'(output_valid), 32'd1);
    check("ar_final_empty", 32'(empty), 32'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule : tb_sample_fifo

`default_nettype wire
